hard_png: RTL and testbench

HARD_PNG -- requirements
Module: hard_png

---
 rtl/hard_png_if.sv | 16 +
 rtl/hard_png.sv | 118 +++++++++++
 tb/tb_hard_png.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hard_png_if.sv
// hard_png_if: byte-stream input and decoded header/pixel output bundle for hard_png
interface hard_png_if;
    logic        istart, ivalid, iready, ostart, ovalid;
    logic [7:0]  ibyte, opixelr, opixelg, opixelb, opixela;
    logic [2:0]  colortype;
    logic [13:0] width;
    logic [31:0] height;
    modport master (
        output istart, ivalid, ibyte,
        input  iready, ostart, colortype, width, height, ovalid, opixelr, opixelg, opixelb, opixela
    );
    modport slave (
        input  istart, ivalid, ibyte,
        output iready, ostart, colortype, width, height, ovalid, opixelr, opixelg, opixelb, opixela
    );
endinterface

// File: rtl/hard_png.sv
// hard_png: streaming PNG decoder for 8-bit, non-interlaced images carried in stored deflate blocks
module hard_png (
    input logic clk,
    input logic rst,
    hard_png_if.slave b
);
    typedef enum logic [2:0] {IDLE, SIG, CHUNK_LEN, CHUNK_TYPE, CHUNK_DATA, CHUNK_CRC, DONE, ERR} state_t;
    typedef enum logic [2:0] {ZHDR, BHDR, BLEN, BRAW, ZEND} zstate_t;
    localparam logic [63:0] PNG_SIG = 64'h8950_4E47_0D0A_1A0A;
    localparam logic [31:0] T_IHDR = 32'h4948_4452, T_IDAT = 32'h4944_4154, T_IEND = 32'h4945_4E44;
    state_t state, state_n;
    zstate_t zs, zs_n;
    logic [31:0] cnt, len, typ, w32, h32, rw, px;
    logic [15:0] blen;
    logic [1:0] zc, comp, last_c;
    logic [2:0] ct_t, ct_map;
    logic [7:0] c0, c1, c2;
    logic bfinal, filt, acc, ihdr, idat, live, pix, mono, ct_ok;
    assign b.iready = ~rst;
    assign acc = b.ivalid && !b.istart;
    assign ihdr = state == CHUNK_DATA && typ == T_IHDR;
    assign idat = state == CHUNK_DATA && typ == T_IDAT;
    assign live = acc && idat && zs == BRAW && rw < h32 && w32 != 0;
    assign last_c = b.colortype == 3'd4 ? 2'd0 : b.colortype[1:0];
    assign pix = live && !filt && comp == last_c;
    assign mono = b.colortype == 3'd0 || b.colortype == 3'd4;
    assign ct_ok = b.ibyte inside {8'd0, 8'd2, 8'd3, 8'd4, 8'd6};
    assign ct_map = b.ibyte == 8'd0 ? 3'd0 : b.ibyte == 8'd4 ? 3'd1 : b.ibyte == 8'd2 ? 3'd2 :
                    b.ibyte == 8'd6 ? 3'd3 : 3'd4;
    always_comb begin
        state_n = state;
        zs_n = zs;
        if (b.istart) state_n = SIG;
        else if (acc)
            case (state)
                SIG:        state_n = b.ibyte != PNG_SIG[8*(7-cnt[2:0]) +: 8] ? ERR : cnt == 7 ? CHUNK_LEN : SIG;
                CHUNK_LEN:  state_n = cnt == 3 ? CHUNK_TYPE : CHUNK_LEN;
                CHUNK_TYPE: state_n = cnt != 3 ? CHUNK_TYPE : len == 0 ? CHUNK_CRC : CHUNK_DATA;
                CHUNK_DATA: state_n = (ihdr && cnt == 8 && b.ibyte != 8'd8) || (ihdr && cnt == 9 && !ct_ok) ||
                                      (idat && zs == BHDR && b.ibyte[2:1] != 2'b00) ? ERR :
                                      cnt == len - 1 ? CHUNK_CRC : CHUNK_DATA;
                CHUNK_CRC:  state_n = cnt != 3 ? CHUNK_CRC : typ == T_IEND ? DONE : CHUNK_LEN;
                default: ;
            endcase
        // zlib framing spans IDAT chunk boundaries, so it only advances on IDAT payload bytes
        if (b.istart) zs_n = ZHDR;
        else if (acc && idat)
            case (zs)
                ZHDR: zs_n = zc == 2'd1 ? BHDR : ZHDR;
                BHDR: zs_n = BLEN;
                BLEN: zs_n = zc != 2'd3 ? BLEN : blen != 16'd0 ? BRAW : bfinal ? ZEND : BHDR;
                BRAW: zs_n = blen != 16'd1 ? BRAW : bfinal ? ZEND : BHDR;
                default: ;
            endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            zs <= ZHDR;
        end else begin
            state <= state_n;
            zs <= zs_n;
        end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {cnt, len, typ, w32, h32, rw, px} <= '0;
            {blen, zc, comp, ct_t, c0, c1, c2, bfinal} <= '0;
            filt <= 1'b1;
            {b.ostart, b.ovalid, b.colortype, b.width, b.height} <= '0;
            {b.opixelr, b.opixelg, b.opixelb, b.opixela} <= '0;
        end else begin
            b.ostart <= 1'b0;
            b.ovalid <= pix;
            if (b.istart) begin
                {cnt, len, typ, w32, h32, rw, px} <= '0;
                {blen, zc, comp, ct_t, bfinal} <= '0;
                filt <= 1'b1;
                {b.colortype, b.width, b.height} <= '0;
            end else if (acc) begin
                cnt <= state_n != state ? '0 : cnt + 1;
                if (state == CHUNK_LEN) len <= {len[23:0], b.ibyte};
                if (state == CHUNK_TYPE) typ <= {typ[23:0], b.ibyte};
                if (ihdr && cnt < 4) w32 <= {w32[23:0], b.ibyte};
                if (ihdr && cnt >= 4 && cnt < 8) h32 <= {h32[23:0], b.ibyte};
                if (ihdr && cnt == 9) ct_t <= ct_map;
                if (ihdr && cnt == 12) begin
                    b.width <= w32[13:0];
                    b.height <= h32;
                    b.colortype <= ct_t;
                    b.ostart <= 1'b1;
                end
                if (idat) begin
                    zc <= zs_n != zs ? 2'd0 : zc + 2'd1;
                    if (zs == BHDR) bfinal <= b.ibyte[0];
                    if (zs == BLEN && zc == 2'd0) blen[7:0] <= b.ibyte;
                    if (zs == BLEN && zc == 2'd1) blen[15:8] <= b.ibyte;
                    if (zs == BRAW) blen <= blen - 16'd1;
                end
                if (live && filt) filt <= 1'b0;
                else if (live) begin
                    comp <= comp == last_c ? 2'd0 : comp + 2'd1;
                    c0 <= comp == 2'd0 ? b.ibyte : c0;
                    c1 <= comp == 2'd1 ? b.ibyte : c1;
                    c2 <= comp == 2'd2 ? b.ibyte : c2;
                    if (comp == last_c) begin
                        b.opixelr <= mono ? b.ibyte : c0;
                        b.opixelg <= mono ? b.ibyte : b.colortype == 3'd1 ? c0 : c1;
                        b.opixelb <= mono || b.colortype == 3'd2 ? b.ibyte : b.colortype == 3'd1 ? c0 : c2;
                        b.opixela <= b.colortype[0] ? b.ibyte : 8'hFF;
                        px <= px == w32 - 1 ? '0 : px + 1;
                        rw <= px == w32 - 1 ? rw + 1 : rw;
                        filt <= px == w32 - 1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hard_png.sv
// tb_hard_png: directed PNG byte streams with hand-computed headers and pixels for hard_png
module tb_hard_png;
    logic clk = 1'b0, rst = 1'b1;
    hard_png_if b();
    hard_png dut (.clk(clk), .rst(rst), .b(b));
    always #5 clk = ~clk;
    localparam logic [31:0] T_IHDR = 32'h4948_4452, T_IDAT = 32'h4944_4154, T_IEND = 32'h4945_4E44,
                            T_TEXT = 32'h7445_5874;
    logic [7:0] s[$];
    logic [31:0] pix[$];
    int n_ostart, n_cmp, n_bad, p0, o0;
    always @(negedge clk) begin
        if (b.ostart) n_ostart++;
        if (b.ovalid) pix.push_back({b.opixelr, b.opixelg, b.opixelb, b.opixela});
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] px_at(input int i);
        return pix.size() > p0 + i ? pix[p0 + i] : 32'hxxxx_xxxx;
    endfunction
    task automatic putn(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) s.push_back(v[8*i +: 8]);
    endtask
    task automatic put4(input logic [31:0] v);
        putn({96'h0, v}, 4);
    endtask
    task automatic png_sig();
        s.delete();
        putn(128'h8950_4E47_0D0A_1A0A, 8);
    endtask
    task automatic ihdr(input logic [31:0] w, input logic [31:0] h, input logic [7:0] d, input logic [7:0] ct);
        put4(32'd13); put4(T_IHDR); put4(w); put4(h);
        putn({88'h0, d, ct, 24'h0}, 5);
        put4(32'h0);
    endtask
    task automatic idat(input int n, input logic [127:0] v);
        put4(n); put4(T_IDAT); putn(v, n); put4(32'h0);
    endtask
    task automatic iend();
        put4(32'h0); put4(T_IEND); put4(32'h0);
    endtask
    task automatic rgba_stream();
        png_sig(); ihdr(2, 1, 8, 6);
        idat(16, 128'h7801_0109_00F6_FF00_1122_3344_5566_7788);
        iend();
    endtask
    // abort raises rst once the first pixel of this stream has appeared
    task automatic play(input bit abort);
        p0 = pix.size();
        o0 = n_ostart;
        @(negedge clk) b.istart = 1'b1;
        @(negedge clk) b.istart = 1'b0;
        foreach (s[i]) begin
            if (abort && pix.size() > p0) rst = 1'b1;
            b.ivalid = 1'b1;
            b.ibyte = s[i];
            @(negedge clk);
        end
        b.ivalid = 1'b0;
        repeat (4) @(negedge clk);
    endtask
    task automatic check_rgba(input string tag);
        check({tag, "_ostart"}, n_ostart - o0, 1);
        check({tag, "_npix"}, pix.size() - p0, 2);
        check({tag, "_pix0"}, px_at(0), 32'h1122_3344);
        check({tag, "_pix1"}, px_at(1), 32'h5566_7788);
    endtask
    initial begin
        b.istart = 1'b0; b.ivalid = 1'b0; b.ibyte = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_iready", b.iready, 0);
        check("rst_ostart", b.ostart, 0);
        check("rst_ovalid", b.ovalid, 0);
        check("rst_hdr", {b.colortype, b.width, b.height}, 0);
        check("rst_pixel", {b.opixelr, b.opixelg, b.opixelb, b.opixela}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_iready", b.iready, 1);
        rgba_stream(); play(0);
        check_rgba("rgba");
        check("rgba_ct", b.colortype, 3);
        check("rgba_w", b.width, 2);
        check("rgba_h", b.height, 1);
        png_sig(); ihdr(2, 1, 8, 0); idat(10, 128'h7801_0103_00FC_FF00_1020); iend(); play(0);
        check("gray_ct", b.colortype, 0);
        check("gray_npix", pix.size() - p0, 2);
        check("gray_pix0", px_at(0), 32'h1010_10FF);
        check("gray_pix1", px_at(1), 32'h2020_20FF);
        png_sig(); ihdr(2, 1, 8, 6);
        idat(10, 128'h7801_0109_00F6_FF00_1122);
        put4(32'd3); put4(T_TEXT); putn(128'h613D62, 3); put4(32'h0);
        idat(6, 128'h3344_5566_7788);
        iend(); play(0);
        check_rgba("split");
        png_sig(); ihdr(1, 2, 8, 4); idat(14, 128'h7801_0107_00F8_FF00_1080_0020_90EE); iend(); play(0);
        check("ga_ct", b.colortype, 1);
        check("ga_h", b.height, 2);
        check("ga_npix", pix.size() - p0, 2);
        check("ga_pix0", px_at(0), 32'h1010_1080);
        check("ga_pix1", px_at(1), 32'h2020_2090);
        png_sig(); ihdr(2, 1, 8, 3); idat(15, 128'h7801_0002_00FD_FF00_0501_0100_FEFF_07); iend(); play(0);
        check("pal_ct", b.colortype, 4);
        check("pal_npix", pix.size() - p0, 2);
        check("pal_pix0", px_at(0), 32'h0505_05FF);
        check("pal_pix1", px_at(1), 32'h0707_07FF);
        png_sig(); ihdr(1, 1, 8, 2); idat(11, 128'h7801_0104_00FB_FF00_AABB_CC); iend(); play(0);
        check("rgb_ct", b.colortype, 2);
        check("rgb_pix0", px_at(0), 32'hAABB_CCFF);
        rgba_stream(); s[3] = 8'h00; play(0);
        check("badsig_ostart", n_ostart - o0, 0);
        check("badsig_npix", pix.size() - p0, 0);
        rgba_stream(); play(0);
        check_rgba("resync");
        png_sig(); ihdr(2, 1, 16, 6); idat(16, 128'h7801_0109_00F6_FF00_1122_3344_5566_7788); iend(); play(0);
        check("depth_ostart", n_ostart - o0, 0);
        check("depth_npix", pix.size() - p0, 0);
        check("depth_iready", b.iready, 1);
        png_sig(); ihdr(2, 1, 8, 5); iend(); play(0);
        check("ctype_ostart", n_ostart - o0, 0);
        png_sig(); ihdr(2, 1, 8, 6); idat(16, 128'h7801_0309_00F6_FF00_1122_3344_5566_7788); iend(); play(0);
        check("btype_ostart", n_ostart - o0, 1);
        check("btype_npix", pix.size() - p0, 0);
        check("btype_iready", b.iready, 1);
        rgba_stream(); play(1);
        check("abort_rst_held", rst, 1);
        check("abort_iready", b.iready, 0);
        check("abort_hdr", {b.colortype, b.width, b.height}, 0);
        check("abort_pixel", {b.opixelr, b.opixelg, b.opixelb, b.opixela}, 0);
        check("abort_ovalid", b.ovalid, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_npix", pix.size() - p0, 1);
        check("abort_pix0", px_at(0), 32'h1122_3344);
        check("abort_iready_after", b.iready, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
